cam_capture_roi: RTL

Parametrised camera capture front-end for the digit-recognition pipeline: synchronises a DVP-style sensor bus (vsync/href/byte data), discards start-up frames, assembles multi-byte pixels, generates pixel coordinates and masks pixels outside a runtime-programmable region of interest. Its outputs feed the colour-space/binarisation/projection chain directly. It replaces the fixed 8→16-bit, fixed-window capture logic with configurable bus width, bytes per pixel, window and frame-size checking.

---
 rtl/cam_capture_roi.sv | 139 +++++++++++++
 1 files changed

// File: rtl/cam_capture_roi.sv
// cam_capture_roi: DVP capture front-end with pixel assembly, coordinates, ROI masking and frame-size check.
// Optional feature: define CAM_ROI_EN for runtime ROI shadow registers and masking.
module cam_capture_roi #(
    parameter int DATA_W = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int H_PIXEL = 480,
    parameter int V_PIXEL = 272,
    parameter int WAIT_FRAME = 10,
    parameter int CNT_W = 11,
    parameter logic [DATA_W*BYTES_PER_PIX-1:0] FILL_VALUE = '1
) (
    input  logic                            cam_pclk,
    input  logic                            rst,
    input  logic                            cam_vsync,
    input  logic                            cam_href,
    input  logic [DATA_W-1:0]               cam_data,
    input  logic [CNT_W-1:0]                roi_x0,
    input  logic [CNT_W-1:0]                roi_x1,
    input  logic [CNT_W-1:0]                roi_y0,
    input  logic [CNT_W-1:0]                roi_y1,
    output logic                            post_frame_vsync,
    output logic                            post_frame_hsync,
    output logic                            post_frame_de,
    output logic [DATA_W*BYTES_PER_PIX-1:0] post_pix,
    output logic [CNT_W-1:0]                post_xpos,
    output logic [CNT_W-1:0]                post_ypos,
    output logic                            post_in_roi,
    output logic                            frame_valid,
    output logic                            frame_done,
    output logic                            size_err
);
    localparam int PIX_W = DATA_W * BYTES_PER_PIX;
    localparam logic [1:0] LAST_BEAT = 2'(BYTES_PER_PIX - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [7:0] WAIT_LIM = 8'(WAIT_FRAME);

    logic vs0_q, vs0_d, hr0_q, hr0_d, vs1_q, vs1_d, hr1_q, hr1_d, vs2_q, vs2_d, hr2_q, hr2_d;
    logic [DATA_W-1:0] dat0_q, dat0_d, dat1_q, dat1_d;
    logic [1:0] beat_q, beat_d;
    logic [PIX_W-1:0] shift_q, shift_d, spix_q, spix_d, opix_q, opix_d;
    logic [CNT_W-1:0] col_q, col_d, row_q, row_d, mcol_q, mcol_d, mc;
    logic [CNT_W-1:0] sx_q, sx_d, sy_q, sy_d, ox_q, ox_d, oy_q, oy_d;
    logic [7:0] wait_q, wait_d;
    logic fv_q, fv_d, sde_q, sde_d, chk_q, chk_d, err_q, err_d;
    logic ovs_q, ovs_d, ohs_q, ohs_d, ode_q, ode_d, ofv_q, ofv_d, odone_q, odone_d, oerr_q, oerr_d;
    logic fs, fall, last, in_roi;

    always_comb begin
        {vs0_d, hr0_d, dat0_d} = {cam_vsync, cam_href, cam_data};
        {vs1_d, hr1_d, dat1_d} = {vs0_q, hr0_q, dat0_q};
        {vs2_d, hr2_d} = {vs1_q, hr1_q};
        fs = vs1_q & ~vs2_q;
        fall = ~hr1_q & hr2_q;
        last = hr1_q && beat_q == LAST_BEAT;
        beat_d = (!hr1_q || last) ? 2'd0 : beat_q + 2'd1;
        shift_d = hr1_q ? PIX_W'({shift_q, dat1_q}) : shift_q;
        col_d = !hr1_q ? '0 : (last && col_q != CNT_MAX) ? col_q + CNT_ONE : col_q;
        row_d = fs ? '0 : (fall && row_q != CNT_MAX) ? row_q + CNT_ONE : row_q;
        mc = col_q > mcol_q ? col_q : mcol_q;
        mcol_d = fs ? '0 : mc;
        wait_d = (fs && wait_q != WAIT_LIM) ? wait_q + 8'd1 : wait_q;
        fv_d = fv_q | (fs && wait_q == WAIT_LIM);
        sde_d = last;
        spix_d = last ? shift_d : spix_q;
        sx_d = last ? col_q : sx_q;
        // a line starting together with the frame start belongs to row 0
        sy_d = last ? (fs ? '0 : row_q) : sy_q;
        chk_d = fs & fv_q;
        err_d = row_q != CNT_W'(V_PIXEL) || mc != CNT_W'(H_PIXEL);
        ovs_d = vs2_q & fv_q;
        ohs_d = hr2_q & fv_q;
        ode_d = sde_q & fv_q;
        opix_d = sde_q ? (in_roi ? spix_q : FILL_VALUE) : opix_q;
        ox_d = sde_q ? sx_q : ox_q;
        oy_d = sde_q ? sy_q : oy_q;
        ofv_d = fv_q;
        odone_d = chk_q;
        oerr_d = chk_q ? err_q : oerr_q;
    end

    always_ff @(posedge cam_pclk) begin
        if (rst) begin
            {vs0_q, hr0_q, dat0_q, vs1_q, hr1_q, dat1_q, vs2_q, hr2_q} <= '0;
            {beat_q, shift_q, col_q, row_q, mcol_q, wait_q, fv_q} <= '0;
            {sde_q, spix_q, sx_q, sy_q, chk_q, err_q} <= '0;
            {ovs_q, ohs_q, ode_q, opix_q, ox_q, oy_q, ofv_q, odone_q, oerr_q} <= '0;
        end else begin
            {vs0_q, hr0_q, dat0_q, vs1_q, hr1_q, dat1_q, vs2_q, hr2_q} <=
                {vs0_d, hr0_d, dat0_d, vs1_d, hr1_d, dat1_d, vs2_d, hr2_d};
            {beat_q, shift_q, col_q, row_q, mcol_q, wait_q, fv_q} <=
                {beat_d, shift_d, col_d, row_d, mcol_d, wait_d, fv_d};
            {sde_q, spix_q, sx_q, sy_q, chk_q, err_q} <= {sde_d, spix_d, sx_d, sy_d, chk_d, err_d};
            {ovs_q, ohs_q, ode_q, opix_q, ox_q, oy_q, ofv_q, odone_q, oerr_q} <=
                {ovs_d, ohs_d, ode_d, opix_d, ox_d, oy_d, ofv_d, odone_d, oerr_d};
        end
    end

`ifdef CAM_ROI_EN
    logic [CNT_W-1:0] x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
    logic oroi_q, oroi_d;

    // window is latched at frame start so mid-frame writes apply to the next frame
    always_comb begin
        in_roi = x0_q <= sx_q && sx_q <= x1_q && y0_q <= sy_q && sy_q <= y1_q;
        x0_d = fs ? roi_x0 : x0_q;
        x1_d = fs ? roi_x1 : x1_q;
        y0_d = fs ? roi_y0 : y0_q;
        y1_d = fs ? roi_y1 : y1_q;
        oroi_d = sde_q ? in_roi : oroi_q;
    end

    always_ff @(posedge cam_pclk) begin
        if (rst) begin
            {x0_q, y0_q, oroi_q} <= '0;
            {x1_q, y1_q} <= {CNT_MAX, CNT_MAX};
        end else begin
            {x0_q, x1_q, y0_q, y1_q, oroi_q} <= {x0_d, x1_d, y0_d, y1_d, oroi_d};
        end
    end

    assign post_in_roi = oroi_q;
`else
    logic roi_unused;
    assign roi_unused = ^{roi_x0, roi_x1, roi_y0, roi_y1};
    assign in_roi = 1'b1;
    assign post_in_roi = 1'b1;
`endif

    assign post_frame_vsync = ovs_q;
    assign post_frame_hsync = ohs_q;
    assign post_frame_de = ode_q;
    assign post_pix = opix_q;
    assign post_xpos = ox_q;
    assign post_ypos = oy_q;
    assign frame_valid = ofv_q;
    assign frame_done = odone_q;
    assign size_err = oerr_q;
endmodule
